// File: rtl/mimosa_pkg.sv
// Shared definitions for the MIMOSA UART reporter: FSM encodings, the default
// sync byte and the packet byte selector.
package mimosa_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_SEND = 2'd1,
        PKT_DONE = 2'd2
    } pkt_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_t;

    // Byte n of the report packet {sync, uo, uio, sync ^ uo ^ uio}.
    function automatic logic [7:0] packet_byte(input logic [1:0] idx,
                                               input logic [7:0] sync,
                                               input logic [7:0] uo,
                                               input logic [7:0] uio);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sync;
            2'd1:    b = uo;
            2'd2:    b = uio;
            default: b = sync ^ uo ^ uio;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer. A new byte can be accepted in the final stop-bit cycle,
// so consecutive bytes go out back-to-back with no idle gap.
module uart_byte_tx
    import mimosa_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_t       state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_end;

    assign bit_end = (baud_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BIT_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_ready   = 1'b0;
        tx         = 1'b1;
        unique case (state_q)
            BIT_IDLE: begin
                tx_ready   = 1'b1;
                baud_cnt_d = '0;
                if (tx_valid) begin
                    state_d = BIT_START;
                    shift_d = tx_data;
                end
            end
            BIT_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d   = BIT_DATA;
                    bit_idx_d = '0;
                end
            end
            BIT_DATA: begin
                tx = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = BIT_STOP;
                end
            end
            BIT_STOP: begin
                // Ready only in the last stop cycle: the next start bit follows directly.
                if (bit_end) begin
                    tx_ready = 1'b1;
                    if (tx_valid) begin
                        state_d = BIT_START;
                        shift_d = tx_data;
                    end else begin
                        state_d = BIT_IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/mimosa_uart_reporter.sv
// Captures the model output bytes on a sample request and reports them over
// UART as a 4-byte packet with sync byte and XOR checksum.
module mimosa_uart_reporter
    import mimosa_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample,
    input  logic [7:0] uo_in,
    input  logic [7:0] uio_in,
    output logic       usb_tx,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    pkt_state_t pkt_q, pkt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [7:0] uo_q, uio_q, overrun_q;
    logic       capture, tx_valid, tx_ready;
    logic [7:0] tx_data;

    // DONE already reports not-busy, so a request on that cycle starts a new packet.
    assign busy        = (pkt_q == PKT_SEND);
    assign capture     = sample && !busy;
    assign overrun_cnt = overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q      <= PKT_IDLE;
            byte_idx_q <= '0;
            uo_q       <= '0;
            uio_q      <= '0;
            overrun_q  <= '0;
        end else begin
            pkt_q      <= pkt_d;
            byte_idx_q <= byte_idx_d;
            if (capture) begin
                uo_q  <= uo_in;
                uio_q <= uio_in;
            end
            if (sample && busy && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    always_comb begin
        pkt_d      = pkt_q;
        byte_idx_d = byte_idx_q;
        tx_valid   = 1'b0;
        tx_data    = SYNC_BYTE;
        unique case (pkt_q)
            PKT_SEND: begin
                if (tx_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        pkt_d = PKT_DONE;
                    end else begin
                        tx_valid   = 1'b1;
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data    = packet_byte(byte_idx_d, SYNC_BYTE, uo_q, uio_q);
                    end
                end
            end
            default: begin
                // Byte 0 is the sync byte, so it can be launched on the capture edge itself.
                pkt_d = PKT_IDLE;
                if (sample) begin
                    tx_valid   = 1'b1;
                    pkt_d      = PKT_SEND;
                    byte_idx_d = 2'd0;
                end
            end
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (usb_tx)
    );

endmodule

// File: tb/tb_mimosa_uart_reporter.sv
// Directed bench for mimosa_uart_reporter with a UART decoder and a scoreboard
// queue of expected bytes.
module tb_mimosa_uart_reporter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample = 1'b0;
    logic [7:0] uo_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       usb_tx;
    logic       busy;
    logic [7:0] overrun_cnt;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic       mon_on = 1'b0;

    always #5 clk = ~clk;

    mimosa_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (sample),
        .uo_in       (uo_in),
        .uio_in      (uio_in),
        .usb_tx      (usb_tx),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    // Returns at the first falling clock edge with busy low, bounded.
    task automatic wait_idle();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("busy_timeout", busy, 1'b0);
    endtask

    task automatic count_busy(output int n);
        n = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
    endtask

    // Line must sit high whenever no packet is in flight.
    always @(negedge clk) begin
        if (mon_on && rst_n && busy === 1'b0) check("idle_line_high", usb_tx, 1'b1);
    end

    // UART decoder: every cycle of every bit must hold the same level.
    logic [9:0] dec_frame;
    logic       dec_stable, dec_abort, dec_v;
    logic [7:0] dec_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && rst_n && usb_tx === 1'b0) begin
                dec_stable = 1'b1;
                dec_abort  = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    if (b > 0) @(negedge clk);
                    dec_v = usb_tx;
                    if (!rst_n) dec_abort = 1'b1;
                    for (int c = 1; c < CPB; c++) begin
                        @(negedge clk);
                        if (usb_tx !== dec_v) dec_stable = 1'b0;
                        if (!rst_n) dec_abort = 1'b1;
                    end
                    dec_frame[b] = dec_v;
                end
                if (dec_abort) begin
                    exp_q.delete();
                end else begin
                    check("uart_byte_expected", exp_q.size() > 0, 1'b1);
                    dec_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    check("uart_byte", dec_frame[8:1], dec_exp);
                    check("uart_stop_bit", dec_frame[9], 1'b1);
                    check("uart_bit_width", dec_stable, 1'b1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n;
    int edges;
    logic prev_tx;

    initial begin
        // Reset, with a sample request that must be ignored
        repeat (2) @(posedge clk);
        #1 sample = 1'b1; uo_in = 8'h77; uio_in = 8'h77;
        @(posedge clk);
        #1 sample = 1'b0;
        @(negedge clk);
        check("reset_tx", usb_tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overrun", overrun_cnt, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1; mon_on = 1'b1;
        repeat (3) @(posedge clk);
        check("idle_after_reset_busy", busy, 1'b0);

        // Single packet A5,3C,81,18 and busy length
        #1 uo_in = 8'h3C; uio_in = 8'h81; sample = 1'b1;
        push4(8'hA5, 8'h3C, 8'h81, 8'h18);
        @(negedge clk);
        check("pre_capture_tx", usb_tx, 1'b1);
        check("pre_capture_busy", busy, 1'b0);
        @(posedge clk);
        #1 sample = 1'b0; uo_in = 8'h00; uio_in = 8'h00;
        @(negedge clk);
        check("start_bit_latency", usb_tx, 1'b0);
        check("busy_rise", busy, 1'b1);
        count_busy(n);
        check("busy_length", n, 160);
        repeat (2) @(negedge clk);
        check("pkt1_all_bytes", exp_q.size(), 0);
        check("pkt1_overrun", overrun_cnt, 8'h00);

        // Two dropped requests during a packet
        @(posedge clk);
        #1 uo_in = 8'h11; uio_in = 8'h22; sample = 1'b1;
        push4(8'hA5, 8'h11, 8'h22, 8'h96);
        @(posedge clk);
        #1 sample = 1'b0;
        repeat (9) @(posedge clk);
        #1 sample = 1'b1; uo_in = 8'hEE; uio_in = 8'hDD;
        @(posedge clk);
        #1 sample = 1'b0;
        repeat (39) @(posedge clk);
        #1 sample = 1'b1; uo_in = 8'h99; uio_in = 8'h66;
        @(posedge clk);
        #1 sample = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("overrun_two", overrun_cnt, 8'h02);
        check("pkt2_all_bytes", exp_q.size(), 0);

        // 300 consecutive requests: two packets accepted, counter saturates
        @(posedge clk);
        #1 uo_in = 8'h5A; uio_in = 8'hC3; sample = 1'b1;
        push4(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        push4(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        repeat (300) @(posedge clk);
        #1 sample = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("overrun_saturated", overrun_cnt, 8'hFF);
        check("pkt3_all_bytes", exp_q.size(), 0);

        // Reset at cycle 70 of a packet
        @(posedge clk);
        #1 uo_in = 8'hAA; uio_in = 8'h55; sample = 1'b1;
        push4(8'hA5, 8'hAA, 8'h55, 8'h5A);
        @(posedge clk);
        #1 sample = 1'b0;
        repeat (69) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_tx", usb_tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_overrun", overrun_cnt, 8'h00);
        edges = 0;
        prev_tx = usb_tx;
        repeat (200) begin
            @(negedge clk);
            if (usb_tx !== prev_tx) edges++;
            prev_tx = usb_tx;
        end
        check("abort_no_edges", edges, 0);
        check("abort_busy_stays_low", busy, 1'b0);
        check("abort_queue_flushed", exp_q.size(), 0);

        // Request on the cycle busy falls starts the next packet
        @(posedge clk);
        #1 uo_in = 8'h12; uio_in = 8'h34; sample = 1'b1;
        push4(8'hA5, 8'h12, 8'h34, 8'h83);
        @(posedge clk);
        #1 sample = 1'b0;
        wait_idle();
        sample = 1'b1; uo_in = 8'h00; uio_in = 8'hFF;
        push4(8'hA5, 8'h00, 8'hFF, 8'h5A);
        @(posedge clk);
        #1 sample = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy, 1'b1);
        check("b2b_start_bit", usb_tx, 1'b0);
        check("b2b_no_drop", overrun_cnt, 8'h00);
        wait_idle();
        repeat (2) @(negedge clk);
        check("b2b_all_bytes", exp_q.size(), 0);
        check("b2b_overrun_final", overrun_cnt, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
